mips_lsu_avalon: RTL and testbench
==================================

// Module: mips_lsu_avalon
// PURPOSE
//  Load/store unit between the multicycle core datapath and the Avalon MM master port of mips_cpu_bus.
//  Accepts one memory op per request, sizes it into byte lanes, holds the bus through waitrequest, and
//  returns load data aligned and sign/zero-extended to the register file. Stalls the FSM (busy_o) for the access.
// PARAMETERS
//  (none; 32-bit little-endian byte lanes, fixed)
// PORTS
//  clk          in   1   core clock
//  reset        in   1   synchronous, active-high reset
//  req_i        in   1   start op; sampled in IDLE only
//  op_i         in   4   mem_op_t: LW LH LHU LB LBU LWL LWR SW SH SB
//  addr_i       in   32  byte address from ALU
//  wdata_i      in   32  store data (rt)
//  rt_old_i     in   32  current rt, merge source for LWL/LWR
//  busy_o       out  1   access in flight; OR'd into FSM stall
//  done_o       out  1   1-cycle pulse: op complete
//  err_o        out  1   1-cycle pulse with done_o: misaligned op, no bus access made
//  rdata_o      out  32  load result, valid when done_o (held until next done_o)
//  address      out  32  Avalon address, always word aligned ({addr_i[31:2],2'b00})
//  read         out  1   Avalon read
//  write        out  1   Avalon write
//  waitrequest  in   1   Avalon waitrequest
//  writedata    out  32  Avalon writedata
//  byteenable   out  4   Avalon byteenable
//  readdata     in   32  Avalon readdata, valid in cycle read=1 && waitrequest=0
// BEHAVIOUR
//  Reset: state IDLE; busy_o, done_o, err_o, read, write = 0; rdata_o, address, writedata = 0; byteenable = 0.
//  States: IDLE, ACCESS, DONE.
//  IDLE: req_i=1 -> latch op, off=addr_i[1:0], rt_old_i, wdata_i; misaligned (LW/SW off!=0, LH/LHU/SH off[0]!=0)
//   -> DONE with err_o=1, no read/write ever asserted; else -> ACCESS. busy_o=1 from cycle after req_i.
//  ACCESS: read (loads) or write (stores) =1, address/byteenable/writedata stable; stay while waitrequest=1.
//   Cycle with waitrequest=0: transfer completes; loads capture readdata into rdata_o (after align); -> DONE.
//  DONE: done_o=1 (and err_o if misaligned), busy_o=0, read=write=0; -> IDLE. Min latency req->done: 2 cycles
//   with waitrequest=0; each waitrequest=1 cycle adds one. req_i in ACCESS/DONE ignored (not queued).
//  byteenable: word 1111; half 0011<<off; byte 0001<<off; LWL (1<<(off+1))-1; LWR 1111<<off (masked to 4 bits).
//  writedata: SW wdata; SH wdata[15:0]<<8*off; SB wdata[7:0]<<8*off; unused lanes 0.
//  Load align (w=readdata): LW w; LB/LBU sign/zero-extend w>>8*off [7:0]; LH/LHU same on [15:0];
//   LWL: (w<<8*(3-off)) | (rt_old & (2^(8*(3-off))-1)); LWR: (w>>8*off) | (rt_old & ~(32'hFFFFFFFF>>8*off)).
//  Reset asserted in any state: next edge returns to reset values; in-flight bus op abandoned, no done_o.
//  read and write never both 1; bus outputs change only on IDLE->ACCESS and ACCESS->DONE edges.
// STRUCTURE
//  Package codes: mem_op_t enum (4-bit), lsu_state_t enum {IDLE,ACCESS,DONE}.
//  Sub-module lsu_load_align (combinational: op, off, readdata, rt_old -> aligned result), reused by bench
//   model. Byteenable/writedata generation and FSM stay in this module.
// TESTING
//  LW addr 0x1000, mem=0xDEADBEEF, waitrequest=0 -> read=1,be=1111 one cycle; done_o 2 cycles after req; rdata 0xDEADBEEF.
//  LB/LBU addr 0x1003, mem=0x80FF0011 -> be=1000; rdata 0xFFFFFF80 / 0x00000080.
//  SH addr 0x2002, wdata 0x1234ABCD -> write=1, address 0x2000, be=1100, writedata 0xABCD0000.
//  LWL off=1 mem=0x44332211 rt_old=0xAABBCCDD -> 0x2211CCDD; LWR off=1 -> 0xAA443322.
//  LW addr 0x1002 -> no read/write, done_o&err_o 1 cycle after req.
//  SW with waitrequest=1 for 3 cycles: signals held stable, done_o on 5th cycle; reset in ACCESS -> write=0 next edge, no done_o.

Source files
------------

// File: rtl/mips_lsu_avalon_pkg.sv
`default_nettype none
// ============================================================================
// Module : mips_lsu_avalon_pkg
// Brief  : Shared types and helpers for the MIPS load/store unit.
// Rev    : 1.0  initial release
// ============================================================================
package mips_lsu_avalon_pkg;

    typedef enum logic [3:0] {
        LW  = 4'd0,
        LH  = 4'd1,
        LHU = 4'd2,
        LB  = 4'd3,
        LBU = 4'd4,
        LWL = 4'd5,
        LWR = 4'd6,
        SW  = 4'd7,
        SH  = 4'd8,
        SB  = 4'd9
    } mem_op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } lsu_state_t;

    function automatic logic op_is_store(input mem_op_t op);
        return (op == SW) || (op == SH) || (op == SB);
    endfunction

    // Undefined opcodes are rejected like misaligned ones so they never reach the bus.
    function automatic logic op_misaligned(input mem_op_t op, input logic [1:0] off);
        logic r;
        case (op)
            LW, SW:       r = (off != 2'b00);
            LH, LHU, SH:  r = off[0];
            LB, LBU, SB,
            LWL, LWR:     r = 1'b0;
            default:      r = 1'b1;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_lsu_avalon_load_align.sv
`default_nettype none
// ============================================================================
// Module : lsu_load_align
// Brief  : Aligns a read word into the register result, with sign/zero
//          extension and LWL/LWR merge against the old rt value.
// Rev    : 1.0  initial release
// ============================================================================
module lsu_load_align
    import mips_lsu_avalon_pkg::*;
(
    input  mem_op_t     i_op,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_readdata,
    input  logic [31:0] i_rt_old,
    output logic [31:0] o_result
);

    logic [31:0] w_shr;
    logic [4:0]  w_lwl_sh;

    assign w_shr    = i_readdata >> {i_off, 3'b000};
    assign w_lwl_sh = {~i_off, 3'b000};

    always_comb begin
        o_result = i_readdata;
        case (i_op)
            LB:  o_result = {{24{w_shr[7]}}, w_shr[7:0]};
            LBU: o_result = {24'h0, w_shr[7:0]};
            LH:  o_result = {{16{w_shr[15]}}, w_shr[15:0]};
            LHU: o_result = {16'h0, w_shr[15:0]};
            // Low bytes below the shifted word are kept from rt.
            LWL: o_result = (i_readdata << w_lwl_sh)
                          | (i_rt_old & ((32'h1 << w_lwl_sh) - 32'h1));
            LWR: o_result = w_shr | (i_rt_old & ~(32'hFFFF_FFFF >> {i_off, 3'b000}));
            default: o_result = i_readdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mips_lsu_avalon.sv
`default_nettype none
// ============================================================================
// Module : mips_lsu_avalon
// Brief  : Load/store unit driving an Avalon-MM master for the multicycle core.
// Rev    : 1.0  initial release
// ============================================================================
module mips_lsu_avalon
    import mips_lsu_avalon_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_i,
    input  logic [3:0]  op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rt_old_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);

    lsu_state_t  r_state, w_next;
    mem_op_t     r_op, w_op;
    logic [1:0]  r_off, w_off;
    logic [31:0] r_rt_old;
    logic        r_err;
    logic        w_misaligned;
    logic        w_store;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_aligned;

    assign w_op         = mem_op_t'(op_i);
    assign w_off        = addr_i[1:0];
    assign w_misaligned = op_misaligned(w_op, w_off);
    assign w_store      = op_is_store(r_op);

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = 32'h0;
        case (w_op)
            LW, SW:      w_be = 4'b1111;
            LH, LHU, SH: w_be = 4'b0011 << w_off;
            LB, LBU, SB: w_be = 4'b0001 << w_off;
            LWL: begin
                case (w_off)
                    2'd0:    w_be = 4'b0001;
                    2'd1:    w_be = 4'b0011;
                    2'd2:    w_be = 4'b0111;
                    default: w_be = 4'b1111;
                endcase
            end
            LWR:         w_be = 4'b1111 << w_off;
            default:     w_be = 4'b0000;
        endcase
        case (w_op)
            SW:      w_wdata = wdata_i;
            SH:      w_wdata = {16'h0, wdata_i[15:0]} << {w_off, 3'b000};
            SB:      w_wdata = {24'h0, wdata_i[7:0]} << {w_off, 3'b000};
            default: w_wdata = 32'h0;
        endcase
    end

    lsu_load_align u_align (
        .i_op       (r_op),
        .i_off      (r_off),
        .i_readdata (readdata),
        .i_rt_old   (r_rt_old),
        .o_result   (w_aligned)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_op       <= LW;
            r_off      <= 2'b00;
            r_rt_old   <= 32'h0;
            r_err      <= 1'b0;
            address    <= 32'h0;
            byteenable <= 4'b0000;
            writedata  <= 32'h0;
            rdata_o    <= 32'h0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && req_i) begin
                r_op     <= w_op;
                r_off    <= w_off;
                r_rt_old <= rt_old_i;
                r_err    <= w_misaligned;
                // Bus fields are only touched when a real transfer starts.
                if (!w_misaligned) begin
                    address    <= {addr_i[31:2], 2'b00};
                    byteenable <= w_be;
                    writedata  <= w_wdata;
                end
            end
            if (r_state == ACCESS && !waitrequest && !w_store) begin
                rdata_o <= w_aligned;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        busy_o = 1'b0;
        done_o = 1'b0;
        err_o  = 1'b0;
        read   = 1'b0;
        write  = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_i) begin
                    w_next = w_misaligned ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                busy_o = 1'b1;
                read   = !w_store;
                write  = w_store;
                if (!waitrequest) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                done_o = 1'b1;
                err_o  = r_err;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_lsu_avalon.sv
`default_nettype none
// ============================================================================
// Module : tb_mips_lsu_avalon
// Brief  : Self-checking bench: directed vector table, reset/wait corner cases,
//          and random ops against a byte-level reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mips_lsu_avalon;
    import mips_lsu_avalon_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_i;
    mem_op_t     op_i;
    logic [31:0] addr_i, wdata_i, rt_old_i;
    logic        busy_o, done_o, err_o;
    logic [31:0] rdata_o, address, writedata, readdata;
    logic        read, write, waitrequest;
    logic [3:0]  byteenable;

    int errors = 0;
    int checks = 0;
    logic [31:0] last_rdata = 32'h0;

    always #5 clk = ~clk;

    mips_lsu_avalon dut (
        .clk         (clk),
        .reset       (reset),
        .req_i       (req_i),
        .op_i        (op_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rt_old_i    (rt_old_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .rdata_o     (rdata_o),
        .address     (address),
        .read        (read),
        .write       (write),
        .waitrequest (waitrequest),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .readdata    (readdata)
    );

    typedef struct {
        mem_op_t     op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rt_old;
        logic [31:0] mem;
        int          waits;
        bit          err;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: works from byte lanes and offsets, not from the RTL shifts.
    function automatic bit m_err(mem_op_t op, int off);
        if (op == LW || op == SW) return off != 0;
        if (op == LH || op == LHU || op == SH) return (off % 2) != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] m_be(mem_op_t op, int off);
        int t;
        case (op)
            LW, SW:      t = 15;
            LH, LHU, SH: t = 3 << off;
            LB, LBU, SB: t = 1 << off;
            LWL:         t = (1 << (off + 1)) - 1;
            LWR:         t = (15 << off) & 15;
            default:     t = 0;
        endcase
        return t[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(mem_op_t op, int off, logic [31:0] w);
        case (op)
            SW:      return w;
            SH:      return (w & 32'hFFFF) << (8 * off);
            SB:      return (w & 32'hFF) << (8 * off);
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_load(mem_op_t op, int off, logic [31:0] mem, logic [31:0] rt);
        logic [7:0]  mb [4];
        logic [7:0]  rb [4];
        logic [7:0]  ob [4];
        logic [7:0]  b;
        logic [15:0] h;
        for (int i = 0; i < 4; i++) begin
            mb[i] = mem[8*i +: 8];
            rb[i] = rt[8*i +: 8];
            ob[i] = 8'h0;
        end
        case (op)
            LW:  return mem;
            LB:  begin b = mb[off]; return {{24{b[7]}}, b}; end
            LBU: return {24'h0, mb[off]};
            LH:  begin h = {mb[off+1], mb[off]}; return {{16{h[15]}}, h}; end
            LHU: begin h = {mb[off+1], mb[off]}; return {16'h0, h}; end
            LWL: begin
                for (int i = 0; i < 4; i++)
                    ob[i] = (i >= 3 - off) ? mb[i - (3 - off)] : rb[i];
                return {ob[3], ob[2], ob[1], ob[0]};
            end
            LWR: begin
                for (int i = 0; i < 4; i++)
                    ob[i] = (i <= 3 - off) ? mb[i + off] : rb[i];
                return {ob[3], ob[2], ob[1], ob[0]};
            end
            default: return 32'h0;
        endcase
    endfunction

    task automatic run_op(input mem_op_t op, input logic [31:0] addr, input logic [31:0] wd_in,
                          input logic [31:0] rt, input logic [31:0] mem, input int waits,
                          input bit hold, input bit e_err, input logic [3:0] e_be,
                          input logic [31:0] e_wd, input logic [31:0] e_rd);
        bit          is_store;
        bit          got;
        int          cyc;
        int          acc;
        logic [31:0] exp_rd;
        is_store = (op == SW) || (op == SH) || (op == SB);
        if (e_err || is_store) begin
            exp_rd = last_rdata;
        end else begin
            exp_rd     = e_rd;
            last_rdata = e_rd;
        end
        @(negedge clk);
        req_i = 1'b1; op_i = op; addr_i = addr; wdata_i = wd_in; rt_old_i = rt;
        waitrequest = 1'b0;
        got = 1'b0; cyc = 0; acc = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            cyc++;
            if (hold) begin
                op_i   = mem_op_t'($urandom_range(0, 15));
                addr_i = $urandom;
            end else begin
                req_i = 1'b0;
            end
            if (done_o) begin
                got = 1'b1;
                chk("latency", cyc, e_err ? 1 : 2 + waits);
                chk("err_o", {31'h0, err_o}, {31'h0, e_err});
                chk("rdata_o", rdata_o, exp_rd);
                chk("busy_in_done", {31'h0, busy_o}, 32'h0);
                chk("rw_in_done", {30'h0, read, write}, 32'h0);
            end else begin
                chk("busy_o", {31'h0, busy_o}, 32'h1);
                chk("read", {31'h0, read}, {31'h0, !e_err && !is_store});
                chk("write", {31'h0, write}, {31'h0, !e_err && is_store});
                chk("address", address, {addr[31:2], 2'b00});
                chk("byteenable", {28'h0, byteenable}, {28'h0, e_be});
                chk("writedata", writedata, e_wd);
                waitrequest = (acc < waits);
                readdata    = waitrequest ? $urandom : mem;
                acc++;
            end
        end
        if (!got) chk("done_timeout", 32'h0, 32'h1);
        req_i = 1'b0;
        waitrequest = 1'b0;
        @(negedge clk);
        chk("done_pulse", {31'h0, done_o}, 32'h0);
    endtask

    initial begin
        bit          saw;
        mem_op_t     op;
        logic [31:0] a, w, r, m;
        int          off, wt;
        bit          e;

        reset = 1'b1; req_i = 1'b0; op_i = LW; addr_i = 32'h0; wdata_i = 32'h0;
        rt_old_i = 32'h0; waitrequest = 1'b0; readdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_flags", {26'h0, busy_o, done_o, err_o, read, write, 1'b0}, 32'h0);
        chk("rst_rdata", rdata_o, 32'h0);
        chk("rst_address", address, 32'h0);
        chk("rst_writedata", writedata, 32'h0);
        chk("rst_be", {28'h0, byteenable}, 32'h0);
        reset = 1'b0;

        vecs[0]  = '{LW,  32'h1000, 32'h0,        32'h0,        32'hDEADBEEF, 0, 1'b0, 4'b1111, 32'h0,        32'hDEADBEEF};
        vecs[1]  = '{LB,  32'h1003, 32'h0,        32'h0,        32'h80FF0011, 0, 1'b0, 4'b1000, 32'h0,        32'hFFFFFF80};
        vecs[2]  = '{LBU, 32'h1003, 32'h0,        32'h0,        32'h80FF0011, 1, 1'b0, 4'b1000, 32'h0,        32'h00000080};
        vecs[3]  = '{SH,  32'h2002, 32'h1234ABCD, 32'h0,        32'h0,        0, 1'b0, 4'b1100, 32'hABCD0000, 32'h0};
        vecs[4]  = '{LWL, 32'h3001, 32'h0,        32'hAABBCCDD, 32'h44332211, 0, 1'b0, 4'b0011, 32'h0,        32'h2211CCDD};
        vecs[5]  = '{LWR, 32'h3001, 32'h0,        32'hAABBCCDD, 32'h44332211, 0, 1'b0, 4'b1110, 32'h0,        32'hAA443322};
        vecs[6]  = '{LW,  32'h1002, 32'h0,        32'h0,        32'h12345678, 0, 1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[7]  = '{SW,  32'h4000, 32'hCAFEF00D, 32'h0,        32'h0,        3, 1'b0, 4'b1111, 32'hCAFEF00D, 32'h0};
        vecs[8]  = '{LH,  32'h5002, 32'h0,        32'h0,        32'h80017FFF, 2, 1'b0, 4'b1100, 32'h0,        32'hFFFF8001};
        vecs[9]  = '{SB,  32'h6001, 32'h000000A5, 32'h0,        32'h0,        0, 1'b0, 4'b0010, 32'h0000A500, 32'h0};
        vecs[10] = '{LHU, 32'h5001, 32'h0,        32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0};

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].rt_old, vecs[i].mem,
                   vecs[i].waits, (i == 7), vecs[i].err, vecs[i].be, vecs[i].wd, vecs[i].rd);
        end

        // Reset while a store is stalled: transfer is dropped with no completion.
        @(negedge clk);
        req_i = 1'b1; op_i = SW; addr_i = 32'h7000; wdata_i = 32'h5A5A5A5A; waitrequest = 1'b1;
        @(negedge clk);
        req_i = 1'b0;
        chk("stall_write", {31'h0, write}, 32'h1);
        @(negedge clk);
        chk("stall_write_held", {31'h0, write}, 32'h1);
        chk("stall_writedata", writedata, 32'h5A5A5A5A);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_access_write", {31'h0, write}, 32'h0);
        chk("rst_access_busy", {31'h0, busy_o}, 32'h0);
        chk("rst_access_addr", address, 32'h0);
        reset = 1'b0;
        waitrequest = 1'b0;
        saw = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done_o) saw = 1'b1;
        end
        chk("rst_access_no_done", {31'h0, saw}, 32'h0);
        chk("rst_access_rdata", rdata_o, 32'h0);
        last_rdata = 32'h0;

        for (int n = 0; n < 80; n++) begin
            op  = mem_op_t'($urandom_range(0, 9));
            a   = $urandom;
            w   = $urandom;
            r   = $urandom;
            m   = $urandom;
            wt  = $urandom_range(0, 3);
            off = int'(a[1:0]);
            e   = m_err(op, off);
            run_op(op, a, w, r, m, wt, ($urandom_range(0, 3) == 0), e,
                   m_be(op, off), m_wdata(op, off, w), e ? 32'h0 : m_load(op, off, m, r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
